team_06_echo_history_buffer: RTL and testbench

Circular sample history that answers the echo effect's look-back requests. Stores each processed sample the echo effect emits on `save_audio`, and on a `search` request returns the sample `offset` positions in the past on `past_output`. It is the responder side of the echo effect's `search`/`offset`/`past_output` interface, and sits between the echo effect and the on-chip sample storage.

---
 rtl/team_06_echo_history_buffer.sv | 117 +++++++++++
 tb/tb_team_06_echo_history_buffer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/team_06_echo_history_buffer.sv
// Circular sample history for the echo effect.
// Stores every emitted sample and answers look-back requests by offset.
module team_06_echo_history_buffer #(
   parameter int DEPTH  = 8192,
   parameter int ADDR_W = 13
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sample_valid,
   input  logic [7:0]        save_audio,
   input  logic              search,
   input  logic [ADDR_W-1:0] offset,
   output logic [7:0]        past_output,
   output logic              past_valid,
   output logic              busy,
   output logic [ADDR_W:0]   fill_count
);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      RESP
   } state_t;

   localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [ADDR_W:0]   fill_q, fill_d;
   logic              hit_q, hit_d;
   logic [7:0]        out_q, out_d;
   logic              pv_q, pv_d;
   logic              busy_q, busy_d;

   logic [7:0]        mem [DEPTH];
   logic [7:0]        rd_data_q;

   // Next-state: write pointer, fill level, lookup FSM and its outputs
   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      rd_addr_d = rd_addr_q;
      fill_d    = fill_q;
      hit_d     = hit_q;
      out_d     = out_q;
      pv_d      = 1'b0;

      if (sample_valid) begin
         wr_ptr_d = wr_ptr_q + ADDR_W'(1);
         if (fill_q != FULL) begin
            fill_d = fill_q + (ADDR_W + 1)'(1);
         end
      end

      unique case (state_q)
         IDLE: begin
            if (search) begin
               // pre-write pointer and level: same-cycle write is not visible
               rd_addr_d = wr_ptr_q - ADDR_W'(1) - offset;
               hit_d     = {1'b0, offset} < fill_q;
               state_d   = READ;
            end
         end
         READ: begin
            state_d = RESP;
         end
         RESP: begin
            out_d   = hit_q ? rd_data_q : 8'd0;
            pv_d    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   // Control registers with synchronous reset; reset aborts any request
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         wr_ptr_q  <= '0;
         rd_addr_q <= '0;
         fill_q    <= '0;
         hit_q     <= 1'b0;
         out_q     <= 8'd0;
         pv_q      <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_addr_q <= rd_addr_d;
         fill_q    <= fill_d;
         hit_q     <= hit_d;
         out_q     <= out_d;
         pv_q      <= pv_d;
         busy_q    <= busy_d;
      end
   end

   // Sample storage: never cleared, read-first on a same-address write
   always_ff @(posedge clk) begin
      if (sample_valid) begin
         mem[wr_ptr_q] <= save_audio;
      end
      if (state_q == READ) begin
         rd_data_q <= mem[rd_addr_q];
      end
   end

   assign past_output = out_q;
   assign past_valid  = pv_q;
   assign busy        = busy_q;
   assign fill_count  = fill_q;

endmodule

// File: tb/tb_team_06_echo_history_buffer.sv
// Directed bench for the echo history buffer (DEPTH=8).
// Expected lookup results are queued on request and checked on past_valid.
module tb_team_06_echo_history_buffer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       sample_valid = 1'b0;
   logic [7:0] save_audio = 8'd0;
   logic       search = 1'b0;
   logic [2:0] offset = 3'd0;
   logic [7:0] past_output;
   logic       past_valid;
   logic       busy;
   logic [3:0] fill_count;

   int tests = 0;
   int fails = 0;
   int pv_count = 0;
   logic [7:0] sb [$];

   team_06_echo_history_buffer #(
      .DEPTH (8),
      .ADDR_W(3)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .sample_valid(sample_valid),
      .save_audio  (save_audio),
      .search      (search),
      .offset      (offset),
      .past_output (past_output),
      .past_valid  (past_valid),
      .busy        (busy),
      .fill_count  (fill_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Scoreboard side: every response pops one queued expectation
   always @(negedge clk) begin
      if (past_valid) begin
         pv_count++;
         if (sb.size() == 0) begin
            chk("unexpected_pv_queue", 32'(sb.size()), 1);
         end else begin
            chk("past_output", 32'(past_output), 32'(sb.pop_front()));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic write(input logic [7:0] v);
      sample_valid = 1'b1;
      save_audio   = v;
      tick();
      sample_valid = 1'b0;
   endtask

   task automatic lookup(input logic [2:0] off, input logic [7:0] exp,
                         input logic wr, input logic [7:0] wv);
      search       = 1'b1;
      offset       = off;
      sample_valid = wr;
      save_audio   = wv;
      sb.push_back(exp);
      tick();
      search       = 1'b0;
      sample_valid = 1'b0;
      chk("busy_n1", 32'(busy), 1);
      tick();
      chk("busy_n2", 32'(busy), 1);
      chk("pv_n2", 32'(past_valid), 0);
      tick();
      chk("pv_n3", 32'(past_valid), 1);
      chk("busy_n3", 32'(busy), 0);
      tick();
      chk("pv_pulse_end", 32'(past_valid), 0);
      chk("sb_drained", 32'(sb.size()), 0);
      chk("out_hold", 32'(past_output), 32'(exp));
   endtask

   initial begin
      int pv0;

      // reset state and empty-buffer lookup
      do_reset();
      chk("rst_out", 32'(past_output), 0);
      chk("rst_pv", 32'(past_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_fill", 32'(fill_count), 0);
      lookup(3'd0, 8'd0, 1'b0, 8'd0);

      // sequential fill
      write(8'd10);
      write(8'd20);
      write(8'd30);
      chk("fill3", 32'(fill_count), 3);
      lookup(3'd0, 8'd30, 1'b0, 8'd0);
      lookup(3'd2, 8'd10, 1'b0, 8'd0);
      lookup(3'd3, 8'd0, 1'b0, 8'd0);

      // wrap-around
      do_reset();
      for (int i = 1; i <= 11; i++) write(8'(i));
      chk("fill_sat", 32'(fill_count), 8);
      chk("wr_ptr", 32'(dut.wr_ptr_q), 3);
      lookup(3'd0, 8'd11, 1'b0, 8'd0);
      lookup(3'd7, 8'd4, 1'b0, 8'd0);
      lookup(3'd3, 8'd8, 1'b0, 8'd0);

      // simultaneous write and search
      do_reset();
      write(8'd5);
      write(8'd6);
      lookup(3'd0, 8'd6, 1'b1, 8'd7);
      chk("fill_sim", 32'(fill_count), 3);
      lookup(3'd0, 8'd7, 1'b0, 8'd0);

      // search while busy is dropped
      pv0 = pv_count;
      search = 1'b1;
      offset = 3'd1;
      sb.push_back(8'd6);
      tick();
      offset = 3'd0;
      tick();
      search = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      chk("drop_pulses", 32'(pv_count - pv0), 1);
      chk("drop_sb", 32'(sb.size()), 0);
      chk("drop_out", 32'(past_output), 6);

      // reset during READ aborts the request
      pv0 = pv_count;
      search = 1'b1;
      offset = 3'd0;
      tick();
      search = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("abort_pulses", 32'(pv_count - pv0), 0);
      chk("abort_fill", 32'(fill_count), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_out", 32'(past_output), 0);

      // full buffer, same-address write during READ returns old data
      for (int i = 0; i < 8; i++) write(8'(50 + i));
      chk("fill_full", 32'(fill_count), 8);
      search = 1'b1;
      offset = 3'd7;
      sb.push_back(8'd50);
      tick();
      search       = 1'b0;
      sample_valid = 1'b1;
      save_audio   = 8'd99;
      tick();
      sample_valid = 1'b0;
      tick();
      tick();
      chk("rf_sb", 32'(sb.size()), 0);
      chk("rf_out", 32'(past_output), 50);
      lookup(3'd0, 8'd99, 1'b0, 8'd0);
      lookup(3'd7, 8'd51, 1'b0, 8'd0);
      chk("fill_stay", 32'(fill_count), 8);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
